// File: rtl/db_front_arb.sv
// Multi-channel key front-end: round-robin arbitration, two-stage fold-hash pipeline, in-order response routing.
// Optional per-channel saturating request/hit counters are enabled by defining DB_FRONT_STATS_EN.
module db_front_arb #(
    parameter int NUM_CH    = 4,
    parameter int KEY_SIZE  = 96,
    parameter int HASH_SIZE = 32,
    parameter int FLAG_SIZE = 4,
    parameter int MAX_OUTST = 8,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W    = $clog2(MAX_OUTST) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*KEY_SIZE-1:0]  in_key,
    input  logic [NUM_CH*FLAG_SIZE-1:0] in_flag,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           in_ready,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [KEY_SIZE-1:0]         req_key,
    output logic [HASH_SIZE-1:0]        req_hash,
    output logic [FLAG_SIZE-1:0]        req_op,
    output logic [CH_W-1:0]             req_ch,
    input  logic                        resp_valid,
    input  logic [FLAG_SIZE-1:0]        resp_flag,
    output logic [NUM_CH-1:0]           out_valid,
    output logic [NUM_CH*FLAG_SIZE-1:0] out_flag,
    output logic [CNT_W-1:0]            outst_cnt,
    output logic                        err_orphan
`ifdef DB_FRONT_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]        stat_req,
    output logic [NUM_CH*32-1:0]        stat_hit
`endif
);

    localparam int AW     = $clog2(MAX_OUTST);
    localparam int NSLICE = KEY_SIZE / HASH_SIZE;

    logic [CH_W-1:0]      rr_ptr;
    logic                 grant_found;
    logic [CH_W-1:0]      grant_idx;
    logic                 s0_valid;
    logic [KEY_SIZE-1:0]  s0_key;
    logic [FLAG_SIZE-1:0] s0_op;
    logic [CH_W-1:0]      s0_ch;
    logic [HASH_SIZE-1:0] s0_hash;
    logic                 s1_take;
    logic                 s0_take;
    logic                 s0_free;
    logic [CNT_W:0]       load;
    logic                 room;
    logic                 in_xfer;
    logic [CH_W-1:0]      route_mem [MAX_OUTST];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [CH_W-1:0]      head_ch;

    // Search from the pointer upward first, then wrap to index 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_found && in_valid[i] && i >= int'(rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_found && in_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(i);
            end
        end
    end

    // valid/ready: a beat moves on a cycle where both are high; once valid is raised,
    // it and its payload hold steady until ready is seen.
    assign s1_take = !req_valid || req_ready;
    assign s0_take = s0_valid && s1_take;
    assign s0_free = !s0_valid || s1_take;
    assign load    = {1'b0, outst_cnt} + {{CNT_W{1'b0}}, s0_valid} + {{CNT_W{1'b0}}, req_valid};
    assign room    = load < (CNT_W+1)'(MAX_OUTST);
    assign in_xfer = !rst && grant_found && s0_free && room;

    always_comb begin
        in_ready = '0;
        if (in_xfer) in_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        s0_hash = '0;
        for (int i = 0; i < NSLICE; i++) s0_hash = s0_hash ^ s0_key[i*HASH_SIZE +: HASH_SIZE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            s0_valid <= 1'b0;
            s0_key   <= '0;
            s0_op    <= '0;
            s0_ch    <= '0;
        end else begin
            if (in_xfer) begin
                rr_ptr   <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
                s0_valid <= 1'b1;
                s0_key   <= in_key[grant_idx*KEY_SIZE +: KEY_SIZE];
                s0_op    <= in_flag[grant_idx*FLAG_SIZE +: FLAG_SIZE];
                s0_ch    <= grant_idx;
            end else if (s0_take) begin
                s0_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid <= 1'b0;
            req_key   <= '0;
            req_hash  <= '0;
            req_op    <= '0;
            req_ch    <= '0;
        end else begin
            if (s0_take) begin
                req_valid <= 1'b1;
                req_key   <= s0_key;
                req_hash  <= s0_hash;
                req_op    <= s0_op;
                req_ch    <= s0_ch;
            end else if (req_ready) begin
                req_valid <= 1'b0;
            end
        end
    end

    // Route FIFO: the extra pointer bit separates full from empty.
    assign push       = req_valid && req_ready;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign pop        = resp_valid && !fifo_empty;
    assign head_ch    = route_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) route_mem[wr_ptr[AW-1:0]] <= req_ch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            outst_cnt  <= '0;
            out_valid  <= '0;
            out_flag   <= '0;
            err_orphan <= 1'b0;
        end else begin
            out_valid <= '0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr                                  <= rd_ptr + 1'b1;
                out_valid[head_ch]                      <= 1'b1;
                out_flag[head_ch*FLAG_SIZE +: FLAG_SIZE] <= resp_flag;
            end
            if (resp_valid && fifo_empty) err_orphan <= 1'b1;
            case ({push, pop})
                2'b10:   outst_cnt <= outst_cnt + 1'b1;
                2'b01:   outst_cnt <= outst_cnt - 1'b1;
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

`ifdef DB_FRONT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_req <= '0;
            stat_hit <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_xfer && grant_idx == CH_W'(c) && stat_req[c*32 +: 32] != 32'hFFFF_FFFF)
                    stat_req[c*32 +: 32] <= stat_req[c*32 +: 32] + 32'd1;
                if (pop && head_ch == CH_W'(c) && resp_flag == FLAG_SIZE'(3)
                    && stat_hit[c*32 +: 32] != 32'hFFFF_FFFF)
                    stat_hit[c*32 +: 32] <= stat_hit[c*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule
